// File: rtl/config_regfile.sv
// Paged, double-buffered configuration register file driven by a host byte stream.
// Optional macro CFG_LOCK_EN adds a sticky LOCK command (0x84) that freezes updates.
module config_regfile #(
    parameter int unsigned               NUM_PAGES   = 1,
    parameter logic [32*NUM_PAGES-1:0]   DEFAULT_CFG = {NUM_PAGES{32'hBBFC_0000}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [7:0]                 data_in,
    output logic [32*NUM_PAGES-1:0]    config_out,
    output logic                       config_update,
    output logic                       dirty,
    output logic                       rd_valid,
    output logic [3:0]                 rd_data,
    output logic                       cmd_err
);

    localparam int unsigned CFG_W = 32 * NUM_PAGES;
    localparam int unsigned NIBS  = CFG_W / 4;
    localparam int unsigned PW    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [CFG_W-1:0] stg_q, stg_d;
    logic [PW-1:0]    page_q, page_d;
    logic             dirty_q, dirty_d;
    logic             update_q, update_d;
    logic             rd_valid_q, rd_valid_d;
    logic [3:0]       rd_data_q, rd_data_d;
    logic             err_q, err_d;
    logic             locked;
    logic [PW+2:0]    wr_field, rd_field;

`ifdef CFG_LOCK_EN
    logic lock_q, lock_d;
    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    assign wr_field = {page_q, data_in[6:4]};
    assign rd_field = {page_q, data_in[2:0]};

    always_comb begin
        cfg_d      = cfg_q;
        stg_d      = stg_q;
        page_d     = page_q;
        dirty_d    = dirty_q;
        update_d   = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        err_d      = err_q;
`ifdef CFG_LOCK_EN
        lock_d     = lock_q;
`endif
        if (enable) begin
            casez (data_in)
                8'b0???_????: begin
                    if (locked) begin
                        err_d = 1'b1;
                    end else begin
                        for (int unsigned n = 0; n < NIBS; n++) begin
                            if (32'(wr_field) == n) stg_d[n*4 +: 4] = data_in[3:0];
                        end
                        dirty_d = 1'b1;
                    end
                end
                8'h80: ;
                8'h81: begin
                    if (locked) begin
                        err_d = 1'b1;
                    end else begin
                        cfg_d    = stg_q;
                        dirty_d  = 1'b0;
                        update_d = 1'b1;
                    end
                end
                8'h82: begin
                    if (locked) begin
                        err_d = 1'b1;
                    end else begin
                        stg_d   = cfg_q;
                        dirty_d = 1'b0;
                    end
                end
                8'h83: begin
                    if (locked) begin
                        err_d = 1'b1;
                    end else begin
                        stg_d    = DEFAULT_CFG;
                        cfg_d    = DEFAULT_CFG;
                        dirty_d  = 1'b0;
                        update_d = 1'b1;
                    end
                end
`ifdef CFG_LOCK_EN
                8'h84: lock_d = 1'b1;
`endif
                8'b101?_????: begin
                    // Out-of-range page keeps the current page and flags the host.
                    if (32'(data_in[4:0]) < NUM_PAGES) page_d = data_in[PW-1:0];
                    else err_d = 1'b1;
                end
                8'b1100_0???: begin
                    for (int unsigned n = 0; n < NIBS; n++) begin
                        if (32'(rd_field) == n) rd_data_d = stg_q[n*4 +: 4];
                    end
                    rd_valid_d = 1'b1;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q      <= DEFAULT_CFG;
            stg_q      <= DEFAULT_CFG;
            page_q     <= '0;
            dirty_q    <= 1'b0;
            update_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 4'h0;
            err_q      <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            stg_q      <= stg_d;
            page_q     <= page_d;
            dirty_q    <= dirty_d;
            update_q   <= update_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

`ifdef CFG_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= 1'b0;
        else        lock_q <= lock_d;
    end
`endif

    assign config_out    = cfg_q;
    assign config_update = update_q;
    assign dirty         = dirty_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign cmd_err       = err_q;

endmodule

// File: tb/tb_config_regfile.sv
// Self-checking bench for config_regfile: one-page and two-page instances driven from a
// vector table, with a readback scoreboard and hand sequences for reset and lock.
module tb_config_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en1, en2;
    logic [7:0]  data;
    logic [31:0] cfg1;
    logic [63:0] cfg2;
    logic        upd1, upd2, dirty1, dirty2, rdv1, rdv2, err1, err2;
    logic [3:0]  rd1, rd2;

    int total = 0;
    int bad   = 0;

    logic [3:0] q1[$];
    logic [3:0] q2[$];

    typedef struct {
        bit          dut;
        bit          en;
        logic [7:0]  d;
        logic [63:0] cfg;
        bit          upd;
        bit          dirty;
        bit          err;
        logic [3:0]  rd;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    config_regfile #(.NUM_PAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .data_in(data),
        .config_out(cfg1), .config_update(upd1), .dirty(dirty1),
        .rd_valid(rdv1), .rd_data(rd1), .cmd_err(err1)
    );

    config_regfile #(.NUM_PAGES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en2), .data_in(data),
        .config_out(cfg2), .config_update(upd2), .dirty(dirty2),
        .rd_valid(rdv2), .rd_data(rd2), .cmd_err(err2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit dut, bit en, logic [7:0] d, logic [63:0] cfg,
                                bit upd, bit dirty, bit err, logic [3:0] rd);
        vec_t v;
        v.dut = dut; v.en = en; v.d = d; v.cfg = cfg;
        v.upd = upd; v.dirty = dirty; v.err = err; v.rd = rd;
        return v;
    endfunction

    // Readback scoreboard: each pulse must match the oldest outstanding READ.
    always @(negedge clk) begin
        if (rst_n && rdv1) begin
            if (q1.size() == 0) chk("rd1_unexpected", 64'(rdv1), 64'd0);
            else chk("rd1_data", 64'(rd1), 64'(q1.pop_front()));
        end
        if (rst_n && rdv2) begin
            if (q2.size() == 0) chk("rd2_unexpected", 64'(rdv2), 64'd0);
            else chk("rd2_data", 64'(rd2), 64'(q2.pop_front()));
        end
    end

    task automatic apply(input vec_t v, input string name);
        data = v.d;
        en1  = v.en && !v.dut;
        en2  = v.en && v.dut;
        if (v.en && v.d[7:3] == 5'b11000) begin
            if (v.dut) q2.push_back(v.rd);
            else       q1.push_back(v.rd);
        end
        @(negedge clk);
        en1 = 1'b0;
        en2 = 1'b0;
        if (v.dut) begin
            chk({name, "_cfg"}, cfg2, v.cfg);
            chk({name, "_upd"}, 64'(upd2), 64'(v.upd));
            chk({name, "_dirty"}, 64'(dirty2), 64'(v.dirty));
            chk({name, "_err"}, 64'(err2), 64'(v.err));
        end else begin
            chk({name, "_cfg"}, {32'h0, cfg1}, v.cfg);
            chk({name, "_upd"}, 64'(upd1), 64'(v.upd));
            chk({name, "_dirty"}, 64'(dirty1), 64'(v.dirty));
            chk({name, "_err"}, 64'(err1), 64'(v.err));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en1   = 1'b0;
        en2   = 1'b0;
        data  = 8'h00;

        // Single page
        tbl.push_back(mk(0, 1, 8'h05, 64'hBBFC0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h1A, 64'hBBFC0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h81, 64'hBBFC00A5, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h80, 64'hBBFC00A5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC0, 64'hBBFC00A5, 0, 0, 0, 4'h5));
        tbl.push_back(mk(0, 1, 8'h7F, 64'hBBFC00A5, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC7, 64'hBBFC00A5, 0, 1, 0, 4'hF));
        tbl.push_back(mk(0, 1, 8'h82, 64'hBBFC00A5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC7, 64'hBBFC00A5, 0, 0, 0, 4'hB));
        tbl.push_back(mk(0, 1, 8'h81, 64'hBBFC00A5, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h43, 64'hBBFC00A5, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h81, 64'hBBF300A5, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h81, 64'hBBF300A5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h83, 64'hBBFC0000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC4, 64'hBBFC0000, 0, 0, 0, 4'hC));
        tbl.push_back(mk(0, 1, 8'hA0, 64'hBBFC0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA1, 64'hBBFC0000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h12, 64'hBBFC0000, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'hC1, 64'hBBFC0000, 0, 1, 1, 4'h2));
        tbl.push_back(mk(0, 1, 8'h81, 64'hBBFC0020, 1, 0, 1, 0));
        // Two pages
        tbl.push_back(mk(1, 1, 8'hA1, 64'hBBFC0000_BBFC0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h23, 64'hBBFC0000_BBFC0000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 8'hC2, 64'hBBFC0000_BBFC0000, 0, 1, 0, 4'h3));
        tbl.push_back(mk(1, 1, 8'h81, 64'hBBFC0300_BBFC0000, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8'hA0, 64'hBBFC0300_BBFC0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8'hC2, 64'hBBFC0300_BBFC0000, 0, 0, 0, 4'h0));
        tbl.push_back(mk(1, 1, 8'h01, 64'hBBFC0300_BBFC0000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 8'h82, 64'hBBFC0300_BBFC0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8'hC0, 64'hBBFC0300_BBFC0000, 0, 0, 0, 4'h0));
        tbl.push_back(mk(1, 1, 8'hA5, 64'hBBFC0300_BBFC0000, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 8'hC2, 64'hBBFC0300_BBFC0000, 0, 0, 1, 4'h0));
        tbl.push_back(mk(1, 1, 8'hFF, 64'hBBFC0300_BBFC0000, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 8'hA1, 64'hBBFC0300_BBFC0000, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 8'hC2, 64'hBBFC0300_BBFC0000, 0, 0, 1, 4'h3));

        #12;
        chk("rst_cfg1", {32'h0, cfg1}, 64'hBBFC0000);
        chk("rst_cfg2", cfg2, 64'hBBFC0000_BBFC0000);
        chk("rst_flags1", {60'h0, upd1, dirty1, rdv1, err1}, 64'h0);
        chk("rst_flags2", {60'h0, upd2, dirty2, rdv2, err2}, 64'h0);
        chk("rst_rd", {56'h0, rd1, rd2}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset mid-sequence drops staged data, sticky error and page select.
        apply(mk(0, 1, 8'h09, 64'hBBFC0020, 0, 1, 1, 0), "pre_rst");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cfg1", {32'h0, cfg1}, 64'hBBFC0000);
        chk("mid_rst_cfg2", cfg2, 64'hBBFC0000_BBFC0000);
        chk("mid_rst_flags", {58'h0, dirty1, err1, dirty2, err2, upd1, upd2}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1, 1, 8'h27, 64'hBBFC0000_BBFC0000, 0, 1, 0, 0), "post_rst_wr");
        apply(mk(1, 1, 8'h81, 64'hBBFC0000_BBFC0700, 1, 0, 0, 0), "post_rst_commit");
        apply(mk(0, 1, 8'hC0, 64'hBBFC0000, 0, 0, 0, 4'h0), "post_rst_rd");

`ifdef CFG_LOCK_EN
        apply(mk(1, 1, 8'h84, 64'hBBFC0000_BBFC0700, 0, 0, 0, 0), "lock");
        apply(mk(1, 1, 8'h0F, 64'hBBFC0000_BBFC0700, 0, 0, 1, 0), "lock_wr");
        apply(mk(1, 1, 8'h81, 64'hBBFC0000_BBFC0700, 0, 0, 1, 0), "lock_commit");
        apply(mk(1, 1, 8'h83, 64'hBBFC0000_BBFC0700, 0, 0, 1, 0), "lock_defaults");
        apply(mk(1, 1, 8'hC0, 64'hBBFC0000_BBFC0700, 0, 0, 1, 4'h0), "lock_rd0");
        apply(mk(1, 1, 8'hC2, 64'hBBFC0000_BBFC0700, 0, 0, 1, 4'h7), "lock_rd2");
`else
        apply(mk(1, 1, 8'h84, 64'hBBFC0000_BBFC0700, 0, 0, 1, 0), "no_lock");
        apply(mk(1, 1, 8'h0F, 64'hBBFC0000_BBFC0700, 0, 1, 1, 0), "no_lock_wr");
        apply(mk(1, 1, 8'hC0, 64'hBBFC0000_BBFC0700, 0, 1, 1, 4'hF), "no_lock_rd");
`endif

        apply(mk(0, 0, 8'h00, 64'hBBFC0000, 0, 0, 0, 0), "idle");
        @(negedge clk);
        #1;
        chk("rd1_pending", 64'(q1.size()), 64'd0);
        chk("rd2_pending", 64'(q2.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
